// File: rtl/controlador_es.sv
// ---------------------------------------------------------------------------
// controlador_es
//   Handshaked I/O sequencer between the processor control FSM and the
//   external 8-bit ports. OUT results are buffered in a circular FIFO and
//   driven out with valid/ready. IN instructions wait, with an optional
//   timeout, for an external valid. The control FSM is stalled whenever a
//   request cannot complete in the current cycle.
//
// Parameters
//   FIFO_DEPTH : output FIFO entries (power of two, >= 2)
//   IN_TIMEOUT : max WAIT_IN cycles before abort; 0 = wait forever
//
// Ports
//   clk        : system clock, rising edge
//   rst        : synchronous active-low reset
//   out_req    : processor executing OUT this cycle
//   out_data   : value to send
//   in_req     : processor executing IN, held until stall=0
//   stall      : combinational stall to the control FSM
//   in_data    : captured input byte (holds until next capture)
//   in_done    : IN completes this cycle
//   in_err     : with in_done, IN ended by timeout
//   pINPUT     : external input byte
//   in_valid   : pINPUT holds valid data
//   in_ack     : pINPUT consumed this cycle
//   pOUTPUT    : FIFO head, 8'h00 when empty
//   out_valid  : FIFO not empty
//   out_ready  : external consumer accepts pOUTPUT
//   out_count  : current FIFO occupancy
// ---------------------------------------------------------------------------
module controlador_es #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IN_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          out_req,
    input  logic [7:0]                    out_data,
    input  logic                          in_req,
    output logic                          stall,
    output logic [7:0]                    in_data,
    output logic                          in_done,
    output logic                          in_err,
    input  logic [7:0]                    pINPUT,
    input  logic                          in_valid,
    output logic                          in_ack,
    output logic [7:0]                    pOUTPUT,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   out_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    // A zero timeout still needs a one-bit counter; it simply saturates.
    localparam int unsigned CW = (IN_TIMEOUT > 0) ? $clog2(IN_TIMEOUT + 1) : 1;

    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0] TO_VAL   = CW'(IN_TIMEOUT);
    localparam logic [CW-1:0] TO_ONE   = 1;
    localparam logic [CW-1:0] TO_MAX   = '1;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // Full comes from the registered count, so a pop in the same cycle
    // does not release a stalled OUT until the next cycle.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = out_req && !w_full;
    assign w_pop   = !w_empty && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; stale entries are masked by the count.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wptr] <= out_data;
        end
    end

    assign out_valid = !w_empty;
    assign pOUTPUT   = w_empty ? 8'h00 : r_mem[r_rptr];
    assign out_count = r_count;

    // ------------------------------------------------------------------
    // Input FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_IN,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_tcnt;
    logic [7:0]    r_in_data;
    logic          r_err;

    logic w_capture;
    logic w_timeout;
    logic w_wait;

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_wait    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_req) begin
                    w_next = S_WAIT_IN;
                end
            end
            S_WAIT_IN: begin
                // A valid byte in the final WAIT_IN cycle beats the timeout.
                if (in_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if ((IN_TIMEOUT != 0) && (r_tcnt == TO_VAL)) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end else begin
                    w_wait = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_tcnt    <= '0;
            r_in_data <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && in_req) begin
                r_tcnt <= '0;
            end else if (w_wait && r_tcnt != TO_MAX) begin
                r_tcnt <= r_tcnt + TO_ONE;
            end
            if (w_capture) begin
                r_in_data <= pINPUT;
                r_err     <= 1'b0;
            end else if (w_timeout) begin
                r_in_data <= 8'h00;
                r_err     <= 1'b1;
            end
        end
    end

    assign in_data = r_in_data;
    assign in_done = (r_state == S_DONE);
    assign in_err  = (r_state == S_DONE) && r_err;

    // Combinational outputs are masked while reset is asserted so that a
    // request held across reset does not stall or consume input.
    assign in_ack = rst && (r_state == S_WAIT_IN) && in_valid;
    assign stall  = rst && ((out_req && w_full) ||
                            (in_req && (r_state != S_DONE)));

endmodule

// File: tb/tb_controlador_es.sv
module tb_controlador_es;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TOUT  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       out_req;
    logic [7:0] out_data;
    logic       in_req;
    logic       stall;
    logic [7:0] in_data;
    logic       in_done;
    logic       in_err;
    logic [7:0] pINPUT;
    logic       in_valid;
    logic       in_ack;
    logic [7:0] pOUTPUT;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_count;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of bytes expected on pOUTPUT, plus occupancy model
    logic [7:0] exp_q[$];
    int         m_count  = 0;
    logic       m_pushed = 1'b0;

    controlador_es #(
        .FIFO_DEPTH(DEPTH),
        .IN_TIMEOUT(TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_req  (out_req),
        .out_data (out_data),
        .in_req   (in_req),
        .stall    (stall),
        .in_data  (in_data),
        .in_done  (in_done),
        .in_err   (in_err),
        .pINPUT   (pINPUT),
        .in_valid (in_valid),
        .in_ack   (in_ack),
        .pOUTPUT  (pOUTPUT),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: check all outputs mid-cycle, then advance through
    // the edge and update the FIFO model with the inputs seen at the edge.
    task automatic cyc(input logic e_in_stall, input logic e_ack,
                       input logic e_done, input logic e_err);
        logic       exp_full;
        logic       exp_stall;
        logic [7:0] exp_head;
        logic       do_push;
        logic       do_pop;
        #2;
        exp_full  = (m_count == DEPTH);
        exp_stall = rst && ((out_req && exp_full) || e_in_stall);
        exp_head  = (m_count != 0) ? exp_q[0] : 8'h00;
        check1("stall", stall, exp_stall);
        check1("in_ack", in_ack, e_ack);
        check1("in_done", in_done, e_done);
        check1("in_err", in_err, e_err);
        check8("out_count", {5'b0, out_count}, 8'(m_count));
        check1("out_valid", out_valid, m_count != 0);
        check8("pOUTPUT", pOUTPUT, exp_head);
        @(posedge clk);
        m_pushed = 1'b0;
        if (!rst) begin
            exp_q.delete();
        end else begin
            do_pop  = (m_count != 0) && out_ready;
            do_push = out_req && !exp_full;
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(out_data);
            m_pushed = do_push;
        end
        m_count = exp_q.size();
        #1;
    endtask

    initial begin
        rst = 1'b0; out_req = 1'b1; in_req = 1'b1; out_data = 8'h99;
        pINPUT = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with both requests high
        check8("rst_in_data", in_data, 8'h00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1; out_req = 1'b0; in_req = 1'b0;

        // Fill with out_ready low
        for (int i = 0; i < 4; i++) begin
            out_req  = 1'b1;
            out_data = 8'((i + 1) * 17);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check8("fill_count", {5'b0, out_count}, 8'd4);
        out_data = 8'h55;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);   // stall=1 from full FIFO
        check8("full_count", {5'b0, out_count}, 8'd4);

        // Drain; 55 enters once the first pop has freed a slot
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (m_pushed) out_req = 1'b0;
            if (m_count == 0 && !out_req) break;
        end
        check8("drain_count", {5'b0, out_count}, 8'd0);

        // Simultaneous push/pop at count 2 across pointer wrap
        out_ready = 1'b0;
        out_req   = 1'b1;
        out_data  = 8'hA0; cyc(1'b0, 1'b0, 1'b0, 1'b0);
        out_data  = 8'hA1; cyc(1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            out_data = 8'hB0 + 8'(i);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check8("pp_count", {5'b0, out_count}, 8'd2);
        end
        out_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b0;

        // IN handshake, in_valid already high
        in_req = 1'b1; in_valid = 1'b1; pINPUT = 8'hA5;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);   // cycle 0
        cyc(1'b1, 1'b1, 1'b0, 1'b0);   // cycle 1
        check8("hs_in_data", in_data, 8'hA5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);   // cycle 2
        in_req = 1'b0; in_valid = 1'b0; pINPUT = 8'h3C;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check8("hs_hold", in_data, 8'hA5);

        // IN timeout
        in_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
        check8("to_in_data", in_data, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);   // cycle 5
        in_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // in_valid in the last WAIT_IN cycle wins over timeout
        in_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
        in_valid = 1'b1; pINPUT = 8'h5A;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);   // cycle 4
        in_valid = 1'b0; pINPUT = 8'h00;
        check8("late_in_data", in_data, 8'h5A);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);   // cycle 5
        in_req = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during WAIT_IN with three FIFO entries
        out_req = 1'b1;
        out_data = 8'hC1; cyc(1'b0, 1'b0, 1'b0, 1'b0);
        out_data = 8'hC2; cyc(1'b0, 1'b0, 1'b0, 1'b0);
        out_data = 8'hC3; cyc(1'b0, 1'b0, 1'b0, 1'b0);
        out_req = 1'b0;
        check8("pre_rst_count", {5'b0, out_count}, 8'd3);
        in_req = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);   // IDLE -> WAIT_IN
        cyc(1'b1, 1'b0, 1'b0, 1'b0);   // WAIT_IN
        rst = 1'b0; in_valid = 1'b1; pINPUT = 8'hEE;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);   // reset edge, no ack
        rst = 1'b1; in_req = 1'b0; in_valid = 1'b0;
        check8("post_rst_in_data", in_data, 8'h00);
        check8("post_rst_count", {5'b0, out_count}, 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_es.md
# controlador_es

Handshaked I/O sequencer between the processor control FSM and the external 8-bit ports. It buffers OUT-instruction results in a small FIFO and drives them out with valid/ready. It executes IN instructions by waiting, with a timeout, for an external valid. It stalls the control FSM (PC load, register write) whenever a request cannot complete in the current cycle.

## Interface
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2
- IN_TIMEOUT, 255, max WAIT_IN cycles before abort; 0 = wait forever
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge)
- out_req  in  1  processor executing OUT this cycle
- out_data  in  8  value to send (ResultULA)
- in_req  in  1  processor executing IN; held high until stall=0
- stall  out  1  combinational; ctrl must not load PC or write registers while 1
- in_data  out  8  captured input, feeds register write-data mux
- in_done  out  1  IN completes this cycle
- in_err  out  1  with in_done: IN ended by timeout
- pINPUT  in  8  external input byte
- in_valid  in  1  pINPUT holds valid data
- in_ack  out  1  pINPUT consumed this cycle
- pOUTPUT  out  8  FIFO head; 8'h00 when empty
- out_valid  out  1  FIFO not empty
- out_ready  in  1  external consumer accepts pOUTPUT
- out_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Output path: circular FIFO with read/write pointers and a count.
  - Push when out_req=1 and not full.
  - Pop when out_valid=1 and out_ready=1.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Output stall: stall_out = out_req and full. Full is the registered state, so a same-cycle pop does not clear the stall. out_req held under stall is pushed on the first cycle full=0.
- Input FSM states: IDLE, WAIT_IN, DONE.
  - IDLE: in_req=1 → WAIT_IN, clear timeout counter. in_valid is ignored in IDLE.
  - WAIT_IN, in_valid=1: in_ack=1, in_data←pINPUT, err←0 → DONE.
  - WAIT_IN, counter reaches IN_TIMEOUT (nonzero) with in_valid=0: in_data←8'h00, err←1 → DONE. Otherwise counter increments.
  - DONE: in_done=1, in_err=err → IDLE.
- Input stall: stall_in = in_req and state≠DONE.
- stall = stall_out or stall_in.
- in_data holds its value until the next capture.
- out_req and in_req in the same cycle are legal; each path follows its own rules.
- Timeout counter width is ceil(log2(IN_TIMEOUT+1)) and it saturates, never wraps.
- Reset (rst=0 at an edge), including mid-transfer:
  - FIFO emptied and pending data dropped; out_count=0, out_valid=0, pOUTPUT=8'h00.
  - Input FSM→IDLE, in_data=8'h00, err=0.
  - in_done, in_ack, in_err=0; stall=0 unless a req is high after reset.

## Timing
- Push→out_valid: 1 cycle. Data is visible on pOUTPUT on the cycle after the push edge.
- pOUTPUT/out_valid are stable while out_valid=1 and out_ready=0.
- IN minimum latency, with in_valid already high:
  - Cycle 0: in_req, stall=1.
  - Cycle 1: WAIT_IN, in_ack=1, stall=1.
  - Cycle 2: DONE, stall=0, in_done=1. The ctrl writes in_data here.
- in_ack is asserted for exactly one cycle per IN, and only in WAIT_IN.
- With IN_TIMEOUT=N:
  - in_err/in_done assert N+2 cycles after the in_req cycle.
  - in_valid arriving in the last WAIT_IN cycle still wins over the timeout.
- The input FSM does not re-enter WAIT_IN on the DONE cycle. A new IN starts only from IDLE (at least 1 cycle gap).

## Test plan
- Reset: hold rst=0 2 cycles with out_req=1 and in_req=1 → stall=0, out_valid=0, pOUTPUT=8'h00, in_data=8'h00, out_count=0.
- FIFO fill and drain, out_ready=0:
  - Push 8'h11,22,33,44 → out_count=4.
  - 5th out_req (8'h55) → stall=1, FIFO unchanged.
  - Raise out_ready → pops 11,22,… in order; 55 is pushed on the cycle after the first pop; no loss or duplicate.
- Simultaneous push/pop at count=2 with out_ready=1 → count stays 2; pointers wrap past FIFO_DEPTH-1 correctly over 10 transfers.
- IN handshake: in_req with in_valid=1, pINPUT=8'hA5 → in_ack on cycle 1, in_done on cycle 2, in_data=8'hA5, in_err=0, stall high exactly 2 cycles.
- IN timeout, IN_TIMEOUT=3, in_valid=0 → in_done=1, in_err=1, in_data=8'h00 on cycle 5. Repeat with in_valid raised in the last WAIT_IN cycle → in_err=0, data captured.
- Reset mid-operation: rst=0 during WAIT_IN with 3 FIFO entries → next cycle IDLE, FIFO empty, no in_ack, no in_done.
